// File: rtl/usb_rx_sie.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_sie
// Purpose  : Full-speed USB receive serial interface engine. Oversamples the
//            single-ended vp/vm lines 4x in the 48 MHz domain, recovers bit
//            timing, NRZI-decodes, removes stuffed bits, detects SYNC and
//            EOP, and delivers packet bytes with start/end/error strobes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_ZEROS  minimum decoded 0 bits before the closing 1 of SYNC (2..7)
// Macro
//   USB_RX_SIE_STUFF_ERR_EN  when defined, a stuffed bit that decodes as 1
//                            aborts the packet with pkt_end + err
// Ports
//   c          in   48 MHz clock (4 samples per 12 Mb/s bit)
//   rst_n      in   asynchronous active-low reset
//   vp, vm     in   D+/D- receive levels, asynchronous to c
//   tx_active  in   local transmitter owns the bus; receiver held idle
//   d          out  received byte, valid with dv, held until the next dv
//   dv         out  one-cycle strobe per received byte
//   pkt_start  out  one-cycle strobe on SYNC detection
//   pkt_end    out  one-cycle strobe on EOP or abort
//   err        out  qualifies pkt_end: 1 = packet bad
//   active     out  high from SYNC detection through the pkt_end cycle
// ============================================================================
module usb_rx_sie #(
  parameter int SYNC_ZEROS = 5
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic       vp,
  input  logic       vm,
  input  logic       tx_active,
  output logic [7:0] d,
  output logic       dv,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       err,
  output logic       active
);

`ifdef USB_RX_SIE_STUFF_ERR_EN
  localparam bit STUFF_ERR = 1'b1;
`else
  localparam bit STUFF_ERR = 1'b0;
`endif

  localparam logic [2:0] SYNC_MIN = 3'(SYNC_ZEROS);

  // Line-state encoding; SE1 folds into SE0.
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
    S_EOP  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and line-state decode
  // --------------------------------------------------------------------------
  logic [1:0] vp_sync;
  logic [1:0] vm_sync;
  logic [1:0] line;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      vp_sync <= 2'b00;
      vm_sync <= 2'b00;
    end else begin
      vp_sync <= {vp_sync[0], vp};
      vm_sync <= {vm_sync[0], vm};
    end
  end

  always_comb begin
    line = LS_SE0;
    if (vp_sync[1] && !vm_sync[1])
      line = LS_J;
    else if (!vp_sync[1] && vm_sync[1])
      line = LS_K;
  end

  // --------------------------------------------------------------------------
  // Bit clock recovery: the phase is 0 in the cycle a new line state first
  // appears, so the sample lands two cycles after every transition and then
  // free-runs every four cycles through runs without transitions.
  // --------------------------------------------------------------------------
  logic [1:0] line_q;
  logic [1:0] phase_q;
  logic [1:0] phase;
  logic       sample;

  assign phase  = (line != line_q) ? 2'd0 : phase_q + 2'd1;
  assign sample = (phase == 2'd2);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= LS_SE0;
      phase_q <= 2'd0;
    end else begin
      line_q  <= line;
      phase_q <= phase;
    end
  end

  // --------------------------------------------------------------------------
  // Receive state machine
  // --------------------------------------------------------------------------
  state_t     state;
  logic [1:0] prev;      // previous J/K sample for NRZI decode
  logic [2:0] zeros;     // SYNC zero count, saturating
  logic [2:0] ones;      // consecutive decoded 1s for destuffing
  logic [2:0] bitcnt;    // bits of the current byte
  logic [1:0] se0cnt;    // consecutive SE0 samples in EOP
  logic [2:0] jcnt;      // consecutive J samples in WAIT
  logic [7:0] shreg;
  logic       bit_val;
  logic [7:0] shifted;

  assign bit_val = (line == prev);
  assign shifted = {bit_val, shreg[7:1]};

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prev      <= LS_J;
      zeros     <= 3'd0;
      ones      <= 3'd0;
      bitcnt    <= 3'd0;
      se0cnt    <= 2'd0;
      jcnt      <= 3'd0;
      shreg     <= 8'h00;
      d         <= 8'h00;
      dv        <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      err       <= 1'b0;
      active    <= 1'b0;
    end else begin
      dv        <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      err       <= 1'b0;
      // active stays high through the pkt_end cycle and drops after it
      if (pkt_end)
        active <= 1'b0;

      if (tx_active) begin
        // Our own transmission owns the bus; a byte completing now is dropped.
        if (state == S_DATA || state == S_EOP) begin
          pkt_end <= 1'b1;
          err     <= 1'b1;
        end
        state <= S_IDLE;
        prev  <= LS_J;
      end else if (sample) begin
        case (state)
          S_IDLE: begin
            prev <= LS_J;
            if (line == LS_K) begin
              state <= S_SYNC;
              zeros <= 3'd1;
              prev  <= LS_K;
            end
          end

          S_SYNC: begin
            if (line == LS_SE0) begin
              state <= S_IDLE;
              prev  <= LS_J;
            end else begin
              prev <= line;
              if (!bit_val) begin
                if (zeros != 3'd7)
                  zeros <= zeros + 3'd1;
              end else if (zeros >= SYNC_MIN) begin
                pkt_start <= 1'b1;
                active    <= 1'b1;
                state     <= S_DATA;
                ones      <= 3'd0;
                bitcnt    <= 3'd0;
              end else begin
                state <= S_IDLE;
                prev  <= LS_J;
              end
            end
          end

          S_DATA: begin
            if (line == LS_SE0) begin
              state  <= S_EOP;
              se0cnt <= 2'd1;
            end else begin
              prev <= line;
              if (ones == 3'd6) begin
                // Stuffed bit: never shifted into the byte.
                ones <= 3'd0;
                if (STUFF_ERR && bit_val) begin
                  pkt_end <= 1'b1;
                  err     <= 1'b1;
                  state   <= S_WAIT;
                  jcnt    <= 3'd0;
                end
              end else begin
                shreg  <= shifted;
                ones   <= bit_val ? ones + 3'd1 : 3'd0;
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                  d  <= shifted;
                  dv <= 1'b1;
                end
              end
            end
          end

          S_EOP: begin
            if (line == LS_J) begin
              pkt_end <= 1'b1;
              err     <= (bitcnt != 3'd0);
              state   <= S_IDLE;
              prev    <= LS_J;
            end else if (line == LS_K || se0cnt == 2'd3) begin
              pkt_end <= 1'b1;
              err     <= 1'b1;
              state   <= S_WAIT;
              jcnt    <= 3'd0;
            end else begin
              se0cnt <= se0cnt + 2'd1;
            end
          end

          S_WAIT: begin
            if (line == LS_J) begin
              if (jcnt == 3'd7) begin
                state <= S_IDLE;
                prev  <= LS_J;
                jcnt  <= 3'd0;
              end else begin
                jcnt <= jcnt + 3'd1;
              end
            end else begin
              jcnt <= 3'd0;
            end
          end

          default: begin
            state <= S_IDLE;
            prev  <= LS_J;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_sie.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_sie
// Purpose  : Self-checking bench for usb_rx_sie. Packets are built at symbol
//            level (SYNC, stuffed NRZI payload, EOP) and replayed with
//            per-edge timing jitter; received bytes and strobes are logged
//            and compared against values derived from the payload.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_sie;

  logic       c = 1'b0;
  logic       rst_n = 1'b0;
  logic       vp = 1'b1;
  logic       vm = 1'b0;
  logic       tx_active = 1'b0;
  logic [7:0] d;
  logic       dv;
  logic       pkt_start;
  logic       pkt_end;
  logic       err;
  logic       active;

  always #5 c = ~c;

  usb_rx_sie #(.SYNC_ZEROS(5)) dut (
    .c         (c),
    .rst_n     (rst_n),
    .vp        (vp),
    .vm        (vm),
    .tx_active (tx_active),
    .d         (d),
    .dv        (dv),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .err       (err),
    .active    (active)
  );

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  int tests = 0;
  int fails = 0;

  // --------------------------------------------------------------------------
  // Output monitor: event counters and a byte log (single writer each)
  // --------------------------------------------------------------------------
  int         n_start = 0, n_end = 0, n_err = 0, n_bytes = 0, n_viol = 0;
  logic [7:0] byte_log [0:1023];

  always @(negedge c) begin
    if (dv) begin
      byte_log[n_bytes[9:0]] <= d;
      n_bytes <= n_bytes + 1;
    end
    if (pkt_start) n_start <= n_start + 1;
    if (pkt_end) n_end <= n_end + 1;
    if (pkt_end && err) n_err <= n_err + 1;
    if ((dv && pkt_end) || (pkt_start && !active) || (pkt_end && !active) ||
        (err && !pkt_end))
      n_viol <= n_viol + 1;
  end

  int b_start, b_end, b_err, b_bytes, b_viol;

  task automatic snap();
    b_start = n_start;
    b_end   = n_end;
    b_err   = n_err;
    b_bytes = n_bytes;
    b_viol  = n_viol;
  endtask

  task automatic chk(input string name, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %0h expected %0h", name, what, act, exp);
    end
  endtask

  task automatic check_pkt(input string name, input int es, input int ee,
                           input int eerr, input int nb, input logic [63:0] data);
    int idx;
    chk(name, "pkt_start count", n_start - b_start, es);
    chk(name, "pkt_end count", n_end - b_end, ee);
    chk(name, "err count", n_err - b_err, eerr);
    chk(name, "byte count", n_bytes - b_bytes, nb);
    for (int k = 0; k < nb; k++) begin
      idx = b_bytes + k;
      chk(name, $sformatf("byte %0d", k), byte_log[idx[9:0]], data[8*k +: 8]);
    end
    chk(name, "strobe rule violations", n_viol - b_viol, 0);
    chk(name, "active after packet", active, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Symbol-level packet builder and player
  // --------------------------------------------------------------------------
  logic [1:0] sym_q [$];
  logic [1:0] cur = LJ;

  task automatic add_sym(input logic [1:0] s);
    sym_q.push_back(s);
    if (s != LSE0) cur = s;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_sym(LJ);
  endtask

  task automatic add_sync();
    add_sym(LK); add_sym(LJ); add_sym(LK); add_sym(LJ);
    add_sym(LK); add_sym(LJ); add_sym(LK); add_sym(LK);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it.
  task automatic add_bit(input logic b);
    add_sym(b ? cur : ~cur);
  endtask

  task automatic add_payload(input logic [63:0] data, input int nbits, input bit stuff);
    int run = 0;
    for (int i = 0; i < nbits; i++) begin
      add_bit(data[i]);
      run = data[i] ? run + 1 : 0;
      if (stuff && run == 6) begin
        add_bit(1'b0);
        run = 0;
      end
    end
  endtask

  task automatic add_eop();
    add_sym(LSE0); add_sym(LSE0); add_sym(LJ);
    add_idle(12);
  endtask

  // Edge i lands at 4*i + j[i], j in {0,1}: bit periods of 3..5 cycles with
  // no cumulative drift. jit: 0 none, 1 alternating 5/3, 2 random.
  task automatic play(input int jit, input int tx_bit);
    int j [$];
    for (int i = 0; i <= sym_q.size(); i++) begin
      if (i == 0 || i == sym_q.size()) j.push_back(0);
      else if (jit == 1) j.push_back(i % 2);
      else if (jit == 2) j.push_back(int'($urandom_range(0, 1)));
      else j.push_back(0);
    end
    for (int i = 0; i < sym_q.size(); i++) begin
      if (i == tx_bit) tx_active = 1'b1;
      {vp, vm} = sym_q[i];
      repeat (4 + j[i+1] - j[i]) @(negedge c);
    end
    sym_q.delete();
  endtask

  task automatic send_packet(input logic [63:0] data, input int nbits,
                             input int jit, input int tx_bit);
    add_idle(4);
    add_sync();
    add_payload(data, nbits, 1'b1);
    add_eop();
    play(jit, tx_bit);
    tx_active = 1'b0;
    repeat (8) @(negedge c);
  endtask

  typedef struct {
    logic [63:0] data;
    int          nbits;
    int          jit;
    int          tx_bit;   // symbol index at which tx_active rises, -1 none
    int          es;
    int          ee;
    int          eerr;
    int          nb;
  } vec_t;

  initial begin : main
    vec_t        vecs [8];
    logic [63:0] rdata;
    int          rbits;

    // symbols: 4 idle + 8 SYNC, so data bit n is symbol 12+n (no stuffing)
    vecs[0] = '{64'h00000000000000A5,  8, 0, -1, 1, 1, 0, 1};
    vecs[1] = '{64'h00000000000001FF, 16, 1, -1, 1, 1, 0, 2};
    vecs[2] = '{64'h00000000000003C5, 12, 0, -1, 1, 1, 1, 1};
    vecs[3] = '{64'h00000000000000A5,  8, 0,  0, 0, 0, 0, 0};
    vecs[4] = '{64'h0000000000000000, 16, 0, 22, 1, 1, 1, 1};
    vecs[5] = '{64'h0000000000123456, 24, 2, -1, 1, 1, 0, 3};
    vecs[6] = '{64'h0000000000FFFF7E, 24, 1, -1, 1, 1, 0, 3};
    vecs[7] = '{64'h0000000000000000, 32, 2, -1, 1, 1, 0, 4};

    // Reset state
    repeat (3) @(negedge c);
    chk("reset", "d", d, 8'h00);
    chk("reset", "dv", dv, 1'b0);
    chk("reset", "pkt_start", pkt_start, 1'b0);
    chk("reset", "pkt_end", pkt_end, 1'b0);
    chk("reset", "err", err, 1'b0);
    chk("reset", "active", active, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge c);

    for (int i = 0; i < 8; i++) begin
      snap();
      send_packet(vecs[i].data, vecs[i].nbits, vecs[i].jit, vecs[i].tx_bit);
      check_pkt($sformatf("vec%0d", i), vecs[i].es, vecs[i].ee, vecs[i].eerr,
                vecs[i].nb, vecs[i].data);
    end

    // Seven consecutive 1s after SYNC, sent without stuffing
    snap();
    add_idle(4);
    add_sync();
    add_payload(64'h1FF, 17, 1'b0);
    add_eop();
    play(0, -1);
    repeat (8) @(negedge c);
`ifdef USB_RX_SIE_STUFF_ERR_EN
    check_pkt("stuff7", 1, 1, 1, 0, 64'h0);
`else
    check_pkt("stuff7", 1, 1, 0, 2, 64'h00FF);
`endif

    // Reset in the middle of a byte
    snap();
    add_idle(4);
    add_sync();
    add_payload(64'h0F, 4, 1'b1);
    play(0, -1);
    chk("rst_mid", "active before reset", active, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid", "d", d, 8'h00);
    chk("rst_mid", "dv", dv, 1'b0);
    chk("rst_mid", "pkt_start", pkt_start, 1'b0);
    chk("rst_mid", "pkt_end", pkt_end, 1'b0);
    chk("rst_mid", "err", err, 1'b0);
    chk("rst_mid", "active", active, 1'b0);
    {vp, vm} = LJ;
    cur = LJ;
    repeat (4) @(negedge c);
    rst_n = 1'b1;
    repeat (10) @(negedge c);
    chk("rst_mid", "pkt_end count", n_end - b_end, 0);
    chk("rst_mid", "byte count", n_bytes - b_bytes, 0);
    snap();
    send_packet(64'h5A, 8, 0, -1);
    check_pkt("after_rst", 1, 1, 0, 1, 64'h5A);

    // Random well-formed packets with random edge jitter
    for (int n = 0; n < 24; n++) begin
      rbits = int'($urandom_range(1, 40));
      rdata = {$urandom(), $urandom()};
      snap();
      send_packet(rdata, rbits, 2, -1);
      check_pkt($sformatf("rand%0d", n), 1, 1, ((rbits % 8) != 0) ? 1 : 0,
                rbits / 8, rdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
